// File: rtl/drive_mode_ctrl.sv
// Power and drive-mode sequencer: long-press power-on, mode ring with a neutral gap.
// Define DRIVE_MODE_AUTO_EN to extend the ring with AUTO (Mode=100).
module drive_mode_ctrl #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_btn,
  input  logic       mode_btn,
  input  logic       moving,
  output logic [2:0] Mode,
  output logic       powered,
  output logic       handover,
  output logic       mode_reject
);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_MANUAL   = 3'd1,
    ST_SEMI     = 3'd2,
    ST_AUTO     = 3'd3,
    ST_HANDOVER = 3'd4
  } state_t;

  function automatic logic [2:0] ring_next(input state_t s);
    case (s)
      ST_MANUAL: ring_next = 3'b010;
`ifdef DRIVE_MODE_AUTO_EN
      ST_SEMI:   ring_next = 3'b100;
`else
      ST_SEMI:   ring_next = 3'b001;
`endif
      ST_AUTO:   ring_next = 3'b001;
      default:   ring_next = 3'b001;
    endcase
  endfunction

  function automatic state_t code_to_state(input logic [2:0] code);
    case (code)
      3'b001:  code_to_state = ST_MANUAL;
      3'b010:  code_to_state = ST_SEMI;
`ifdef DRIVE_MODE_AUTO_EN
      3'b100:  code_to_state = ST_AUTO;
`endif
      default: code_to_state = ST_OFF;
    endcase
  endfunction

  function automatic logic [2:0] state_to_mode(input state_t s);
    case (s)
      ST_MANUAL: state_to_mode = 3'b001;
      ST_SEMI:   state_to_mode = 3'b010;
      ST_AUTO:   state_to_mode = 3'b100;
      default:   state_to_mode = 3'b000;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    target_q, target_d;
  logic          armed_q, armed_d;
  logic          reject_d;
  logic          p_meta_q, p_s_q, p_dly_q;
  logic          m_meta_q, m_s_q, m_dly_q;
  logic          p_edge_s, m_edge_s, pwr_act_s;

  assign p_edge_s  = p_s_q & ~p_dly_q;
  assign m_edge_s  = m_s_q & ~m_dly_q;
  assign pwr_act_s = p_edge_s & armed_q;

  // Button synchronizers plus edge-detect delay stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_meta_q <= 1'b0; p_s_q <= 1'b0; p_dly_q <= 1'b0;
      m_meta_q <= 1'b0; m_s_q <= 1'b0; m_dly_q <= 1'b0;
    end else begin
      p_meta_q <= power_btn; p_s_q <= p_meta_q; p_dly_q <= p_s_q;
      m_meta_q <= mode_btn;  m_s_q <= m_meta_q; m_dly_q <= m_s_q;
    end
  end

  // Next-state logic; outputs are derived from the next state so they register in step
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    target_d = target_q;
    armed_d  = armed_q | ~p_s_q;
    reject_d = 1'b0;
    case (state_q)
      ST_OFF: begin
        gap_d = '0;
        if (!p_s_q) begin
          hold_d = '0;
        end else if (armed_q && hold_q == HOLD_LAST) begin
          state_d = ST_MANUAL;
          hold_d  = '0;
          armed_d = 1'b0;
        end else if (armed_q && hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end else begin
          hold_d = hold_q;
        end
      end
      ST_MANUAL, ST_SEMI
`ifdef DRIVE_MODE_AUTO_EN
      , ST_AUTO
`endif
      : begin
        hold_d = '0;
        gap_d  = '0;
        if (pwr_act_s) begin
          state_d = ST_OFF;
          armed_d = 1'b0;
        end else if (m_edge_s && !moving) begin
          state_d  = ST_HANDOVER;
          target_d = ring_next(state_q);
        end else if (m_edge_s) begin
          reject_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_HANDOVER: begin
        hold_d = '0;
        if (pwr_act_s) begin
          state_d = ST_OFF;
          armed_d = 1'b0;
          gap_d   = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = code_to_state(target_q);
          gap_d   = '0;
        end else if (gap_q != '1) begin
          gap_d = gap_q + 1'b1;
        end else begin
          gap_d = gap_q;
        end
      end
      default: begin
        state_d  = ST_OFF;
        hold_d   = '0;
        gap_d    = '0;
        target_d = 3'b001;
        armed_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      hold_q      <= '0;
      gap_q       <= '0;
      target_q    <= 3'b001;
      armed_q     <= 1'b0;
      Mode        <= 3'b000;
      powered     <= 1'b0;
      handover    <= 1'b0;
      mode_reject <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      target_q    <= target_d;
      armed_q     <= armed_d;
      Mode        <= state_to_mode(state_d);
      powered     <= (state_d != ST_OFF);
      handover    <= (state_d == ST_HANDOVER);
      mode_reject <= reject_d;
    end
  end

endmodule

// File: doc/drive_mode_ctrl.md
Name: drive_mode_ctrl

Overview:
- Power and drive-mode sequencer for the car.
- Produces the 3-bit one-hot Mode bus that selects which control source (manual or semi-auto) drives the turn/move signals; 3'b000 forces all drive signals to zero.
- Handles long-press power-on, power-off, mode cycling and a mandatory neutral gap between modes.
- Refuses mode changes while the car is moving.

Parameters:
- HOLD_CYCLES, 100_000_000: consecutive cycles the synchronized power_btn must stay high to power on (1 s at 100 MHz).
- GAP_CYCLES, 50_000_000: cycles Mode is held at 3'b000 during a mode handover.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- power_btn  in  1  raw power button level, asynchronous to clk.
- mode_btn  in  1  raw mode button level, asynchronous to clk.
- moving  in  1  OR of the currently muxed move_forward/move_backward signals.
- Mode  out  3  one-hot mode: 000 off/neutral, 001 manual, 010 semi-auto, 100 auto (optional).
- powered  out  1  high in any state except OFF.
- handover  out  1  high while in HANDOVER.
- mode_reject  out  1  single-cycle pulse when a mode request is refused.

Interface:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- All outputs are registered.

Behaviour:
- Reset (rst_n=0, asynchronous): state=OFF, Mode=000, powered=0, handover=0, mode_reject=0, counters=0, armed=0, target=001.
- Synchronization:
  - Both buttons pass through 2-FF synchronizers (p_s, m_s), plus one delay register each for edge detection.
  - An edge is defined as sync & ~delayed.
  - A pin rising before clk edge k produces its edge term after edge k+1; the state reacts at edge k+2.
- armed flag: cleared on reset and on every power transition (on or off); set when p_s=0. Power actions are taken only when armed=1, so a press must be released before it can act again.
- State OFF:
  - hold_cnt increments each cycle p_s=1 && armed=1; it clears when p_s=0.
  - When hold_cnt reaches HOLD_CYCLES-1 with p_s still 1: go to MANUAL, Mode=001, powered=1, armed cleared.
  - mode_btn edges are ignored.
- States MANUAL / SEMI (and AUTO if enabled):
  - Power-button rising edge with armed=1: go to OFF, Mode=000, powered=0, armed cleared. This has priority over a same-cycle mode edge.
  - Mode edge with moving=0: go to HANDOVER, Mode=000, handover=1, gap_cnt=0, target=next mode in ring 001->010->001.
  - Mode edge with moving=1: state unchanged; mode_reject=1 for exactly one cycle.
- State HANDOVER:
  - gap_cnt increments each cycle; mode edges are ignored and produce no reject.
  - When gap_cnt reaches GAP_CYCLES-1: Mode=target, handover=0, enter the matching state. Mode is therefore 000 for exactly GAP_CYCLES cycles.
  - Power edge with armed=1: go to OFF immediately; gap is abandoned, handover=0.
  - moving is don't-care here (Mode=000 already zeros the drive signals).
- Counter widths: $clog2(param)+1 bits. Counters saturate and never wrap.
- Reset mid-handover or mid-hold returns to OFF at once; no partial state survives.
- Illegal state encodings recover to OFF with all outputs at reset values.

Optional Feature:
- Macro: DRIVE_MODE_AUTO_EN.
- Defined: mode ring becomes 001->010->100->001; state AUTO drives Mode=100 and behaves like MANUAL/SEMI.
- Undefined: ring is 001<->010 only; Mode never equals 100.

Test Plan (all cases use HOLD_CYCLES=4, GAP_CYCLES=3):
- Power-on hold: power_btn high 10 cycles -> powered=1, Mode=001 exactly 4 cycles after p_s rises. Then a 2-cycle pulse from reset -> Mode stays 000, hold_cnt back to 0.
- Mode switch idle: in MANUAL, moving=0, mode_btn pulse -> handover=1 and Mode=000 for exactly 3 cycles, then Mode=010, handover=0. A second pulse returns to 001.
- Reject while moving: in SEMI, moving=1, mode_btn pulse -> Mode stays 010, mode_reject high exactly 1 cycle.
- Power-off during handover: mode_btn pulse, then power_btn edge on the 2nd HANDOVER cycle -> Mode=000, powered=0, handover=0. Holding power_btn continuously does not re-power until released and held 4 more cycles.
- Simultaneous edges: power and mode edges in the same cycle from MANUAL -> OFF, no handover, no reject.
- Async reset: assert rst_n=0 mid-gap, between clock edges -> all outputs 0 immediately. With DRIVE_MODE_AUTO_EN, three idle mode presses give the sequence 010, 100, 001.
